// File: rtl/hit_generator_stream.sv
// Trigger-driven playback of a loadable hit-word RAM window onto a valid/ready stream.
// Optional HITGEN_TRIG_QUEUE_EN: multi-deep trigger queue (default build keeps a single pending trigger).
module hit_generator_stream #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 8,
  parameter int TRIGQ_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] cfg_start,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_ready,
  output logic              busy,
  output logic              hitgen_done,
  output logic [TRIGQ_W-1:0] trig_pending,
  output logic              trig_overflow,
  input  logic              ovf_clear
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_DRAIN} state_t;

  localparam logic [TRIGQ_W-1:0] PEND_MAX = '1;

  state_t              state;
  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0]   ram_q;
  logic                rd_vld;
  logic                rd_last;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   len_r;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   d0, d1;
  logic                v0, v1, l0, l1;
  logic [TRIGQ_W-1:0]  pend;
  logic                ovf_r;

  logic                in_burst;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   len_c;
  logic [ADDR_W-1:0]   cnt_c;
  logic                pop;
  logic [1:0]          occ;
  logic                can_issue;
  logic                issue;
  logic                last_rd;
  logic                stage_empty;
  logic                busy_c;
  logic                more_pending;
  logic                ovf_evt;
  logic                trig_acc;
  logic                start_go;

  always_comb begin
    in_burst    = (state == S_START) || (state == S_STREAM);
    rd_addr     = (state == S_START) ? cfg_start : cur_addr;
    len_c       = (state == S_START) ? cfg_len : len_r;
    cnt_c       = (state == S_START) ? '0 : cnt;
    pop         = v0 & dout_ready;
    // words held or in flight; a read may issue only if its data will find a free slot
    occ         = {1'b0, v0} + {1'b0, v1} + {1'b0, rd_vld};
    can_issue   = pop ? (occ <= 2'd2) : (occ <= 2'd1);
    issue       = in_burst & can_issue;
    last_rd     = issue & (cnt_c == len_c);
    stage_empty = ~(v0 | v1 | rd_vld);
    busy_c      = in_burst | ~stage_empty;
`ifdef HITGEN_TRIG_QUEUE_EN
    ovf_evt      = trigger & (pend == PEND_MAX);
    more_pending = (pend != '0);
`else
    ovf_evt      = trigger & (busy_c | (pend != '0));
    more_pending = 1'b0;
`endif
    trig_acc = trigger & ~ovf_evt;
    start_go = 1'b0;
    case (state)
      S_IDLE:            start_go = (pend != '0) | trig_acc;
      S_START, S_STREAM: start_go = last_rd & more_pending;
      default:           start_go = 1'b0;
    endcase
  end

  // RAM: read-first on a same-address write, contents never reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (issue) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pend     <= '0;
      ovf_r    <= 1'b0;
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
      cur_addr <= '0;
      len_r    <= '0;
      cnt      <= '0;
      d0       <= '0;
      d1       <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      l0       <= 1'b0;
      l1       <= 1'b0;
    end else begin
`ifdef HITGEN_TRIG_QUEUE_EN
      pend <= pend + TRIGQ_W'(trig_acc) - TRIGQ_W'(start_go);
`else
      if (trig_acc) pend <= TRIGQ_W'(1);
      else if (state == S_START) pend <= '0;
`endif
      if (ovf_evt) ovf_r <= 1'b1;
      else if (ovf_clear) ovf_r <= 1'b0;

      case (state)
        S_IDLE: if (start_go) state <= S_START;
        S_START, S_STREAM: begin
          if (state == S_START) len_r <= cfg_len;
          if (issue) begin
            cur_addr <= rd_addr + ADDR_W'(1);
            cnt      <= cnt_c + ADDR_W'(1);
            if (last_rd) state <= start_go ? S_START : S_DRAIN;
            else         state <= S_STREAM;
          end else if (state == S_START) begin
            cur_addr <= cfg_start;
            cnt      <= '0;
            state    <= S_STREAM;
          end
        end
        S_DRAIN: if (stage_empty) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      rd_vld  <= issue;
      rd_last <= last_rd;

      // two-entry skid; d0 is the visible output word
      if (pop) begin
        if (v1) begin
          d0 <= d1;
          l0 <= l1;
          if (rd_vld) begin
            d1 <= ram_q;
            l1 <= rd_last;
          end else begin
            v1 <= 1'b0;
          end
        end else if (rd_vld) begin
          d0 <= ram_q;
          l0 <= rd_last;
        end else begin
          v0 <= 1'b0;
        end
      end else if (rd_vld) begin
        if (!v0) begin
          d0 <= ram_q;
          l0 <= rd_last;
          v0 <= 1'b1;
        end else begin
          d1 <= ram_q;
          l1 <= rd_last;
          v1 <= 1'b1;
        end
      end
    end
  end

  assign dout          = d0;
  assign dout_valid    = v0;
  assign dout_last     = l0;
  assign busy          = busy_c;
  assign hitgen_done   = ~busy_c & (pend == '0);
  assign trig_pending  = pend;
  assign trig_overflow = ovf_r;

endmodule

// File: tb/tb_hit_generator_stream.sv
// Directed/randomized bench for hit_generator_stream against a word-queue reference model.
module tb_hit_generator_stream;

`ifdef HITGEN_TRIG_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic [7:0]  cfg_start;
  logic [7:0]  cfg_len;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_ready;
  logic        busy;
  logic        hitgen_done;
  logic [1:0]  trig_pending;
  logic        trig_overflow;
  logic        ovf_clear;

  hit_generator_stream #(.DATA_W(64), .ADDR_W(8), .TRIGQ_W(2)) dut (
    .clk(clk), .reset(reset), .trigger(trigger),
    .cfg_start(cfg_start), .cfg_len(cfg_len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
    .busy(busy), .hitgen_done(hitgen_done), .trig_pending(trig_pending),
    .trig_overflow(trig_overflow), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [63:0] d; logic l;} word_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_ram [256];
  word_t       expq[$];
  int          rdy_pct = 100;
  int          cyc = 0;
  int          acc_cnt, first_cyc, last_cyc, peak_pend;

  task automatic chkw(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // expected burst: L = len+1 words from start, address wrapping mod 256
  task automatic enqueue_burst(int start, int len);
    word_t w;
    for (int i = 0; i <= len; i++) begin
      w.d = model_ram[(start + i) % 256];
      w.l = (i == len);
      expq.push_back(w);
    end
  endtask

  task automatic cycle();
    word_t       w;
    logic        fire, stall;
    logic [63:0] hd;
    logic        hl;
    fire  = dout_valid && dout_ready && !reset;
    stall = dout_valid && !dout_ready && !reset;
    hd    = dout;
    hl    = dout_last;
    if (fire) begin
      chkb("word_expected", expq.size() != 0, 1'b1);
      if (expq.size() != 0) begin
        w = expq.pop_front();
        chkw("dout", dout, w.d);
        chkb("dout_last", dout_last, w.l);
      end
      if (acc_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (stall) begin
      chkb("stall_valid", dout_valid, 1'b1);
      chkw("stall_dout", dout, hd);
      chkb("stall_last", dout_last, hl);
    end
    if (int'(trig_pending) > peak_pend) peak_pend = int'(trig_pending);
    dout_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic write_ram(int a, logic [63:0] d);
    wr_en = 1'b1; wr_addr = 8'(a); wr_data = d;
    model_ram[a] = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic new_test();
    acc_cnt = 0; first_cyc = 0; last_cyc = 0; peak_pend = 0;
  endtask

  task automatic run_until_words(int n, int budget);
    for (int i = 0; i < budget && acc_cnt < n; i++) cycle();
    chkw("word_count", 64'(acc_cnt), 64'(n));
  endtask

  task automatic settle();
    for (int i = 0; i < 4; i++) cycle();
    chkb("queue_drained", expq.size() == 0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; trigger = 1'b0; cfg_start = '0; cfg_len = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; dout_ready = 1'b1; ovf_clear = 1'b0;
    new_test();
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chkw("rst_dout", dout, 64'd0);
    chkb("rst_valid", dout_valid, 1'b0);
    chkb("rst_last", dout_last, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", hitgen_done, 1'b1);
    chkw("rst_pending", 64'(trig_pending), 64'd0);
    chkb("rst_ovf", trig_overflow, 1'b0);

    // 1: RAM[i]=i, window 0..19, latency and done timing
    for (int i = 0; i < 256; i++) write_ram(i, 64'(i));
    cfg_start = 8'd0; cfg_len = 8'd19;
    new_test();
    enqueue_burst(0, 19);
    trigger = 1'b1;
    cycle();
    trigger = 1'b0;
    chkb("t1_busy_rise", busy, 1'b1);
    chkb("t1_valid_t1", dout_valid, 1'b0);
    chkw("t1_pending_start", 64'(trig_pending), QEN ? 64'd0 : 64'd1);
    cycle();
    chkb("t1_valid_t2", dout_valid, 1'b0);
    cycle();
    chkb("t1_valid_t3", dout_valid, 1'b1);
    chkw("t1_first_word", dout, 64'd0);
    run_until_words(20, 200);
    chkb("t1_busy_fall", busy, 1'b0);
    chkb("t1_done", hitgen_done, 1'b1);
    chkw("t1_contiguous", 64'(last_cyc - first_cyc), 64'd19);
    settle();

    // 2: random contents, window wrapping past the top address
    for (int i = 0; i < 256; i++) write_ram(i, {$urandom, $urandom});
    cfg_start = 8'd250; cfg_len = 8'd9;
    new_test();
    enqueue_burst(250, 9);
    trigger = 1'b1; cycle(); trigger = 1'b0;
    run_until_words(10, 200);
    settle();

    // 3: burst of 8 with random backpressure
    cfg_start = 8'($urandom_range(0, 255)); cfg_len = 8'd7;
    new_test();
    enqueue_burst(int'(cfg_start), 7);
    rdy_pct = 50;
    trigger = 1'b1; cycle(); trigger = 1'b0;
    run_until_words(8, 2000);
    rdy_pct = 100;
    dout_ready = 1'b1;
    settle();

    // 4: three extra triggers during a 4-word burst
    cfg_start = 8'($urandom_range(0, 255)); cfg_len = 8'd3;
    new_test();
    for (int k = 0; k < (QEN ? 4 : 1); k++) enqueue_burst(int'(cfg_start), 3);
    trigger = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    trigger = 1'b0;
    run_until_words(QEN ? 16 : 4, 400);
    chkw("t4_back_to_back", 64'(last_cyc - first_cyc), QEN ? 64'd15 : 64'd3);
    chkw("t4_peak_pending", 64'(peak_pend), QEN ? 64'd3 : 64'd1);
    chkb("t4_ovf", trig_overflow, !QEN);
    settle();
    ovf_clear = 1'b1; cycle(); ovf_clear = 1'b0;
    chkb("t4_ovf_cleared", trig_overflow, 1'b0);

    // 5: overflow with 5 triggers while busy, then clear behaviour
    cfg_start = 8'($urandom_range(0, 255)); cfg_len = 8'd30;
    new_test();
    for (int k = 0; k < (QEN ? 4 : 1); k++) enqueue_burst(int'(cfg_start), 30);
    trigger = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    trigger = 1'b0;
    chkw("t5_pending_sat", 64'(trig_pending), QEN ? 64'd3 : 64'd0);
    chkb("t5_ovf_set", trig_overflow, 1'b1);
    ovf_clear = 1'b1; cycle(); ovf_clear = 1'b0;
    chkb("t5_ovf_clear", trig_overflow, 1'b0);
    trigger = 1'b1; ovf_clear = 1'b1; cycle(); trigger = 1'b0; ovf_clear = 1'b0;
    chkb("t5_ovf_clear_vs_event", trig_overflow, 1'b1);
    ovf_clear = 1'b1; cycle(); ovf_clear = 1'b0;
    chkb("t5_ovf_clear2", trig_overflow, 1'b0);
    run_until_words(QEN ? 124 : 31, 1000);
    settle();

    // 6: reset on the 5th word of a 20-word burst, then replay
    cfg_start = 8'($urandom_range(0, 255)); cfg_len = 8'd19;
    new_test();
    enqueue_burst(int'(cfg_start), 19);
    trigger = 1'b1; cycle(); trigger = 1'b0;
    run_until_words(4, 200);
    chkb("t6_fifth_valid", dout_valid, 1'b1);
    reset = 1'b1;
    expq.delete();
    cycle();
    reset = 1'b0;
    chkw("t6_rst_dout", dout, 64'd0);
    chkb("t6_rst_valid", dout_valid, 1'b0);
    chkb("t6_rst_last", dout_last, 1'b0);
    chkb("t6_rst_busy", busy, 1'b0);
    chkb("t6_rst_done", hitgen_done, 1'b1);
    chkw("t6_rst_pending", 64'(trig_pending), 64'd0);
    chkb("t6_rst_ovf", trig_overflow, 1'b0);
    cycle();
    new_test();
    enqueue_burst(int'(cfg_start), 19);
    trigger = 1'b1; cycle(); trigger = 1'b0;
    run_until_words(20, 200);
    chkb("t6_done", hitgen_done, 1'b1);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
